// File: rtl/tdp18_split_port_responder.sv
// tdp18_split_port_responder: split-mode 18-bit TDP36K half-port RAM responder with init sweep.
// Define TDP18_RDATA_OUTREG_EN to add a second read-data register stage (read latency 2).
module tdp18_split_port_responder #(
  parameter int DEPTH_WORDS   = 1024,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic        CLK_i,
  input  logic        RST_i,
  input  logic [2:0]  MODE_i,
  input  logic [13:0] ADDR_i,
  input  logic [17:0] WDATA_i,
  input  logic        REN_i,
  input  logic        WEN_i,
  input  logic [1:0]  BE_i,
  input  logic        FLUSH_i,
  output logic [17:0] RDATA_o,
  output logic        READY_o,
  output logic        ERR_o
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic {S_INIT, S_IDLE} state_t;
  state_t      r_state, w_state_nxt;
  logic [9:0]  r_cnt, w_cnt_nxt;
  logic        r_ready, r_err, w_ready_nxt, w_init_we, w_user_we;
  logic [17:0] r_mem [DEPTH_WORDS];
  logic [17:0] r_rd;
  logic [AW-1:0] w_idx;
  logic        w_m9, w_m4, w_m2, w_m1, w_sub, w_bad;
  logic [3:0]  w_sh;
  logic [17:0] w_word, w_sub_mask, w_wmask, w_wdata, w_rsel;
  assign w_idx = ADDR_i[4 +: AW];
  assign w_m9  = MODE_i == 3'b001;
  assign w_m4  = MODE_i == 3'b100;
  assign w_m2  = MODE_i == 3'b110;
  assign w_m1  = MODE_i == 3'b101;
  assign w_sub = w_m4 | w_m2 | w_m1;
  assign w_bad = !(w_m9 | w_sub | (MODE_i == 3'b010));
  assign w_word = r_mem[w_idx];
  // Narrow modes share one shift-and-mask path; mode 9 lane select is explicit for the parity bit.
  always_comb begin
    w_sh       = w_m4 ? {ADDR_i[3:2], 2'b00} : w_m2 ? {ADDR_i[3:1], 1'b0} : ADDR_i[3:0];
    w_sub_mask = w_m4 ? 18'h0000F : w_m2 ? 18'h00003 : 18'h00001;
    w_wmask    = w_m9  ? ((ADDR_i[3] ? 18'h2FF00 : 18'h100FF) & {18{BE_i[0]}})
               : w_sub ? ((w_sub_mask << w_sh) & {18{BE_i[0]}})
               : {BE_i[1], BE_i[0], {8{BE_i[1]}}, {8{BE_i[0]}}};
    w_wdata    = w_m9  ? {WDATA_i[16], WDATA_i[16], WDATA_i[7:0], WDATA_i[7:0]}
               : w_sub ? ({14'b0, WDATA_i[3:0]} << w_sh)
               : WDATA_i;
    w_rsel     = w_m9  ? (ADDR_i[3] ? {1'b0, w_word[17], 8'b0, w_word[15:8]}
                                    : {1'b0, w_word[16], 8'b0, w_word[7:0]})
               : w_sub ? ((w_word >> w_sh) & w_sub_mask)
               : w_word;
  end
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      r_state <= INIT_ON_RESET ? S_INIT : S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  always_comb begin
    w_state_nxt = (r_state == S_INIT && r_cnt == 10'(DEPTH_WORDS - 1)) ? S_IDLE : r_state;
    w_cnt_nxt   = (r_state == S_INIT) ? r_cnt + 10'd1 : r_cnt;
  end
  always_comb begin
    w_ready_nxt = r_state == S_IDLE;
    w_init_we   = !RST_i && r_state == S_INIT;
    w_user_we   = !RST_i && r_ready && WEN_i;
  end
  always_ff @(posedge CLK_i) begin
    if (w_init_we)
      r_mem[r_cnt[AW-1:0]] <= '0;
    else if (w_user_we)
      r_mem[w_idx] <= (w_word & ~w_wmask) | (w_wdata & w_wmask);
  end
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= '0;
    end else begin
      r_ready <= w_ready_nxt;
      if (r_ready && (REN_i || WEN_i) && w_bad) r_err <= 1'b1;
      r_rd    <= FLUSH_i ? 18'h0 : (r_ready && REN_i) ? w_rsel : r_rd;
    end
  end
`ifdef TDP18_RDATA_OUTREG_EN
  logic [17:0] r_rd2;
  always_ff @(posedge CLK_i) begin
    if (RST_i) r_rd2 <= '0;
    else       r_rd2 <= FLUSH_i ? 18'h0 : r_rd;
  end
  assign RDATA_o = r_rd2;
`else
  assign RDATA_o = r_rd;
`endif
  assign READY_o = r_ready;
  assign ERR_o   = r_err;
endmodule
